// File: rtl/cpu_stat_display.sv
// Board-level statistics viewer: shows one of five CPU words as 8 hex digits on a
// multiplexed active-low 7-segment display, with a debounced button to pick the source.
module cpu_stat_display #(
    parameter int SCAN_DIV   = 17,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] led_data_in,
    input  logic        led_cpu_enable,
    input  logic [31:0] total_cycles,
    input  logic [31:0] condi_branch_num,
    input  logic [31:0] uncondi_branch_num,
    input  logic [31:0] bubble_num,
    input  logic        mode_btn,
    output logic [2:0]  mode,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]          sync_q;
    logic                stable;
    logic [DEB_W-1:0]    deb_cnt;
    logic [SCAN_DIV-1:0] div;
    logic [2:0]          idx;
    logic [31:0]         snapshot;
    logic                fresh;
    logic                mode_chg_q;

    logic        btn_sync;
    logic        deb_flip;
    logic        mode_adv;
    logic        tick;
    logic        frame_start;
    logic [31:0] src;
    logic [3:0]  nibble;
    logic [6:0]  seg7;

    assign btn_sync    = sync_q[1];
    assign deb_flip    = (btn_sync != stable) && (deb_cnt == DEB_LAST);
    // Only the press edge of the debounced button advances the source.
    assign mode_adv    = deb_flip && !stable;
    assign tick        = &div;
    assign frame_start = tick && (idx == 3'd7);

    always_comb begin
        case (mode)
            3'd1:    src = total_cycles;
            3'd2:    src = condi_branch_num;
            3'd3:    src = uncondi_branch_num;
            3'd4:    src = bubble_num;
            default: src = led_data_in;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            stable     <= 1'b0;
            deb_cnt    <= '0;
            mode       <= 3'd0;
            div        <= '0;
            idx        <= 3'd0;
            snapshot   <= 32'd0;
            fresh      <= 1'b0;
            mode_chg_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync_q <= {sync_q[0], mode_btn};

            if (btn_sync == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                stable  <= ~stable;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end

            if (mode_adv) begin
                mode <= (mode == 3'd4) ? 3'd0 : mode + 3'd1;
            end
            mode_chg_q <= mode_adv;

            div <= div + SCAN_DIV'(1);
            if (tick) begin
                idx <= idx + 3'd1;
            end

            // Reload only at frame start or right after a source switch: no tearing mid-frame.
            if (frame_start || mode_chg_q) begin
                snapshot <= src;
            end

            if (led_cpu_enable) begin
                fresh <= 1'b1;
            end else if (mode_adv) begin
                fresh <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves seg7 unassigned (no latch).
        seg7   = 7'h7F;
        nibble = snapshot[{idx, 2'b00} +: 4];
        case (nibble)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

    assign an  = ~(8'b1 << idx);
    assign seg = {~((idx == 3'd7) && (mode == 3'd0) && fresh), seg7};

endmodule

// File: tb/tb_cpu_stat_display.sv
// Scoreboard bench for cpu_stat_display: a cycle-level reference model pushes the
// expected {mode, an, seg} after every clock edge; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cpu_stat_display;

    localparam int SCAN_DIV = 2;
    localparam int DEB      = 4;
    localparam int DIGIT    = 1 << SCAN_DIV;
    localparam int FRAME    = 8 * DIGIT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] led_data_in;
    logic        led_cpu_enable;
    logic [31:0] total_cycles;
    logic [31:0] condi_branch_num;
    logic [31:0] uncondi_branch_num;
    logic [31:0] bubble_num;
    logic        mode_btn;
    logic [2:0]  mode;
    logic [7:0]  an;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    cpu_stat_display #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
        .clk                (clk),
        .rst                (rst),
        .led_data_in        (led_data_in),
        .led_cpu_enable     (led_cpu_enable),
        .total_cycles       (total_cycles),
        .condi_branch_num   (condi_branch_num),
        .uncondi_branch_num (uncondi_branch_num),
        .bubble_num         (bubble_num),
        .mode_btn           (mode_btn),
        .mode               (mode),
        .an                 (an),
        .seg                (seg)
    );

    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   rand_on = 0;

    // Reference model state: time since reset, button history, and the visible word.
    int          n;
    bit          s1, s2, stable_m;
    bit          hist[$];
    int          mode_m;
    logic [31:0] snap_m;
    bit          pend_m;
    bit          fresh_m;
    int          nn;
    bit          flip, chg, alld;

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s @%0t: got mode=%0d an=%h seg=%h, want mode=%0d an=%h seg=%h",
                      name, $time, got.mode, got.an, got.seg, want.mode, want.an, want.seg);
    endtask

    function automatic logic [31:0] pick(input int m);
        case (m)
            1:       return total_cycles;
            2:       return condi_branch_num;
            3:       return uncondi_branch_num;
            4:       return bubble_num;
            default: return led_data_in;
        endcase
    endfunction

    function automatic exp_t expect_now();
        exp_t       e;
        int         digit;
        logic [7:0] one;
        logic [3:0] nib;
        one    = 8'd1;
        digit  = (n / DIGIT) % 8;
        nib    = snap_m[digit*4 +: 4];
        e.mode = 3'(mode_m);
        e.an   = ~(one << digit);
        e.seg  = {!(digit == 7 && mode_m == 0 && fresh_m), HEX7[nib]};
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0; s1 = 0; s2 = 0; stable_m = 0; hist.delete();
            mode_m = 0; snap_m = 32'd0; pend_m = 0; fresh_m = 0;
            exp_q.delete();
            exp_q.push_back(expect_now());
        end else begin
            nn = n + 1;
            if (nn % FRAME == 0 || pend_m) snap_m = pick(mode_m);
            // Stable flips once the synchronized button has disagreed for DEB edges in a row.
            hist.push_back(s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            flip = 0;
            if (hist.size() == DEB) begin
                alld = 1;
                foreach (hist[i]) if (hist[i] == stable_m) alld = 0;
                flip = alld;
            end
            if (flip) begin
                stable_m = !stable_m;
                hist.delete();
            end
            chg = flip && stable_m;
            s2 = s1;
            s1 = mode_btn;
            if (chg) mode_m = (mode_m + 1) % 5;
            pend_m = chg;
            if (led_cpu_enable) fresh_m = 1;
            else if (chg) fresh_m = 0;
            n = nn;
            exp_q.push_back(expect_now());
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("scan", {mode, an, seg}, exp_q.pop_front());
    end

    task automatic step();
        @(negedge clk);
        if (rand_on) begin
            led_cpu_enable = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) led_data_in = $urandom;
            if ($urandom_range(0, 5) == 0) total_cycles = $urandom;
            if ($urandom_range(0, 5) == 0) condi_branch_num = $urandom;
            if ($urandom_range(0, 5) == 0) uncondi_branch_num = $urandom;
            if ($urandom_range(0, 5) == 0) bubble_num = $urandom;
        end
    endtask

    task automatic press(input int hold, input int gap);
        mode_btn = 1'b1;
        repeat (hold) step();
        mode_btn = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        rst = 1'b1;
        led_data_in = 32'd0; led_cpu_enable = 1'b0; mode_btn = 1'b0;
        total_cycles = 32'h0000ABCD; condi_branch_num = 32'h0BAD_CAFE;
        uncondi_branch_num = 32'h0013_5790; bubble_num = 32'd5;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        led_data_in = 32'h12345678;
        repeat (2 * FRAME) step();

        press(3, 10);
        press(10, 10);
        for (int k = 0; k < 5; k++) press(8, 8);

        led_cpu_enable = 1'b1; step(); led_cpu_enable = 1'b0;
        repeat (FRAME + 4) step();
        press(8, FRAME);

        for (int k = 0; k < 6 && mode_m != 4; k++) press(8, 8);
        bubble_num = 32'd5;
        repeat (FRAME + 6) step();
        bubble_num = 32'd6;
        repeat (2 * FRAME) step();

        // Land a CPU LED pulse on the same edge as the 4 -> 0 switch.
        mode_btn = 1'b1;
        repeat (5) step();
        led_cpu_enable = 1'b1; step(); led_cpu_enable = 1'b0;
        repeat (4) step();
        mode_btn = 1'b0;
        repeat (FRAME + 8) step();

        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("async_rst", {mode, an, seg}, {3'd0, 8'hFE, 8'hC0});
        @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 4) step();

        rand_on = 1;
        for (int k = 0; k < 300; k++) press($urandom_range(1, 8), $urandom_range(1, 10));
        rand_on = 0;
        led_cpu_enable = 1'b0;
        repeat (2 * FRAME) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cpu_stat_display.md
Name: cpu_stat_display

Overview:
- Consumer end of the CPU's LED/statistics output interface.
- Takes the CPU's led_data_in/led_cpu_enable pair and its four 32-bit performance counters, and shows one selected 32-bit word as 8 hex digits on a time-multiplexed, active-low 7-segment display.
- A debounced push-button cycles the displayed source.
- Sits at the board top level between the CPU and the display pins.

Parameters:
- SCAN_DIV, 17, width of the scan divider; each digit is held for 2^SCAN_DIV clk cycles.
- DEB_CYCLES, 1000000, number of consecutive cycles the synchronized button must disagree with its stable value before the stable value flips (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- led_data_in  input  32  CPU LED data word (already registered by the CPU)
- led_cpu_enable  input  1  one-cycle pulse: CPU LED syscall retired
- total_cycles  input  32  CPU cycle counter
- condi_branch_num  input  32  taken conditional branch counter
- uncondi_branch_num  input  32  unconditional jump counter
- bubble_num  input  32  load-use bubble counter
- mode_btn  input  1  asynchronous push-button, active-high
- mode  output  3  current display source, 0..4
- an  output  8  digit enables, active-low, an[i] selects hex digit i (digit 0 = bits 3:0)
- seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset, asynchronous, applies to all registers and takes effect mid-operation without waiting for a clock edge. Reset values:
  - mode=0, divider=0, digit index=0, snapshot=0, fresh=0
  - debounce stable=0, debounce counter=0, sync flops=0
  - outputs: an=8'hFE, seg=8'hC0
- Button path:
  - 2-flop synchronizer on mode_btn feeds a debounce counter.
  - When sync equals stable, the counter clears.
  - Otherwise the counter increments. When the count reaches DEB_CYCLES-1 and sync still differs, stable flips and the counter clears.
- Mode:
  - A 0->1 transition of stable advances mode by one cycle: 0 led_data_in, 1 total_cycles, 2 condi_branch_num, 3 uncondi_branch_num, 4 bubble_num.
  - mode wraps 4 -> 0. Values 5..7 are unreachable.
  - The stable 1->0 transition has no effect.
- Scan:
  - The divider increments every cycle and ticks when all ones (SCAN_DIV bits).
  - Each tick advances the 3-bit digit index, wrapping 7 -> 0.
  - an = ~(8'b1 << index).
  - seg[6:0] = hex decode of snapshot nibble [index*4+3 : index*4].
- Snapshot:
  - The 32-bit snapshot register loads the source selected by the current mode on either of two events:
    - the tick where the index wraps 7 -> 0 (frame start);
    - the cycle after any mode change.
  - If both events fall in the same cycle, a single load occurs using the current mode.
  - This keeps the display tear-free within a frame.
- Fresh flag:
  - Set on the cycle led_cpu_enable=1.
  - Cleared on any mode change; set wins if both occur in the same cycle.
  - seg[7] = 0 (dp lit) only when index=7, mode=0 and fresh=1; otherwise seg[7] = 1.
- Decode, active-low {g..a}:
  - 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78
  - 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E
- Output timing:
  - an, seg and mode are combinational from registers only; there is no combinational path from any input.
  - Latency from a source change to the display is at most one frame (8*2^SCAN_DIV cycles), or 1 cycle after a mode change.

Test Plan:
All scenarios use SCAN_DIV=2 and DEB_CYCLES=4.
1. Assert rst mid-frame, asynchronously between edges -> an=FE, seg=C0, mode=0 immediately; the first snapshot occurs 32 cycles after release.
2. Drive led_data_in=32'h12345678 and run 64 cycles -> an steps FE, FD, FB … 7F every 4 cycles; at an=FE seg=80 ('8'); at an=FD seg=F8 ('7'); at an=7F seg=F9 ('1').
3. Pulse mode_btn for 3 cycles -> mode stays 0. Hold it for 10 cycles -> mode=1 exactly once. With total_cycles=32'h0000ABCD, the snapshot reads ABCD one cycle after the change, and the digit 0 segment pattern is A1 ('d').
4. Perform five clean presses -> mode goes 1, 2, 3, 4, 0.
5. In mode 0, pulse led_cpu_enable -> at an=7F, seg[7]=0. Press the button -> seg[7]=1 thereafter. Pulse led_cpu_enable on the same cycle as a mode change -> fresh=1.
6. Change bubble_num from 5 to 6 mid-frame in mode 4 -> digit 0 keeps showing '5' until the next frame start, then shows '6' (seg=82).
